// File: rtl/mnist_cfg_pkg.sv
// Shared configuration for the MNIST frame classifier: state encoding,
// default geometry and a counter-width helper.
package mnist_cfg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        WAIT = ST_WAIT,
        DONE = ST_DONE
    } state_t;

    localparam int DEF_IMG_W       = 28;
    localparam int DEF_IMG_H       = 28;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_LOGIT_W     = 32;

    // Bits needed to hold every value in 0..value (never less than 1).
    function automatic int width_of(input int value);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if (value >= (1 << i)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/argmax_acc.sv
// Running signed argmax over one frame of logits; ties keep the lowest index.
module argmax_acc #(
    parameter int LOGIT_W = 32,
    parameter int IDX_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      valid,
    input  logic signed [LOGIT_W-1:0] data,
    output logic        [IDX_W-1:0]   best_idx,
    output logic signed [LOGIT_W-1:0] best_score
);

    logic [IDX_W-1:0] idx;
    logic             have;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            have       <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (start) begin
            idx        <= '0;
            have       <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (valid) begin
            // first logit loads unconditionally; later ones must be strictly greater
            if (!have || data > best_score) begin
                best_score <= data;
                best_idx   <= idx;
            end
            have <= 1'b1;
            idx  <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mnist_frame_classifier.sv
// Frame controller around the layer pipeline: counts pixels in, collects
// logits back, reports argmax with length/timeout status on a held result port.
//
//  state | meaning
//  IDLE  | waiting for the first pixel of a frame
//  LOAD  | accepting pixels until the frame count is reached
//  WAIT  | pipeline busy, collecting logits under a timeout
//  DONE  | result held on m_* until m_ready
module mnist_frame_classifier
    import mnist_cfg_pkg::*;
#(
    parameter int PIX_W          = 8,
    parameter int IMG_W          = DEF_IMG_W,
    parameter int IMG_H          = DEF_IMG_H,
    parameter int NUM_CLASSES    = DEF_NUM_CLASSES,
    parameter int LOGIT_W        = DEF_LOGIT_W,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [PIX_W-1:0]               s_pixel,
    input  logic                           s_last,
    output logic                           core_valid_in,
    output logic [PIX_W-1:0]               core_pixel,
    input  logic [LOGIT_W-1:0]             core_result,
    input  logic                           core_result_valid,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(NUM_CLASSES)-1:0] m_class,
    output logic [LOGIT_W-1:0]             m_score,
    output logic                           m_err_len,
    output logic                           m_err_timeout,
    output logic                           stray_logit,
    output logic [15:0]                    frame_cnt
);

    localparam int TOTAL_PIX = IMG_W * IMG_H;
    localparam int PIX_CNT_W = width_of(TOTAL_PIX);
    localparam int LCNT_W    = width_of(NUM_CLASSES);
    localparam int TMR_W     = width_of(TIMEOUT_CYCLES);
    localparam int CLS_W     = $clog2(NUM_CLASSES);

    state_t               state, state_nxt;
    logic [PIX_CNT_W-1:0] pix_cnt, pix_cnt_nxt;
    logic [LCNT_W-1:0]    logit_cnt;
    logic [TMR_W-1:0]     timer;
    logic                 accept, frame_full, logit_in_wait, logits_full, timer_tc;

    assign accept        = s_valid & s_ready;
    assign pix_cnt_nxt   = (state == IDLE) ? PIX_CNT_W'(1) : pix_cnt + PIX_CNT_W'(1);
    assign frame_full    = accept && (pix_cnt_nxt == PIX_CNT_W'(TOTAL_PIX));
    assign logit_in_wait = core_result_valid && (state == WAIT);
    assign logits_full   = logit_in_wait && (logit_cnt + LCNT_W'(1) == LCNT_W'(NUM_CLASSES));
    assign timer_tc      = (state == WAIT) && (timer == TMR_W'(1));
    assign m_valid       = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: begin
                if (frame_full)  state_nxt = WAIT;
                else if (accept) state_nxt = LOAD;
            end
            // a logit on the expiry cycle is counted first, so completion wins
            WAIT:    if (logits_full || timer_tc) state_nxt = DONE;
            DONE:    if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            s_ready       <= 1'b0;
            core_valid_in <= 1'b0;
            core_pixel    <= '0;
            pix_cnt       <= '0;
            logit_cnt     <= '0;
            timer         <= '0;
            m_err_len     <= 1'b0;
            m_err_timeout <= 1'b0;
            stray_logit   <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            // registered so the first pixel after a handshake lands one cycle later
            s_ready       <= (state_nxt == IDLE) || (state_nxt == LOAD);
            core_valid_in <= accept;
            if (accept) begin
                core_pixel <= s_pixel;
                pix_cnt    <= pix_cnt_nxt;
                m_err_len  <= ((state == IDLE) ? 1'b0 : m_err_len)
                              | (s_last != (pix_cnt_nxt == PIX_CNT_W'(TOTAL_PIX)));
            end
            if (accept && state == IDLE)
                m_err_timeout <= 1'b0;
            else if (timer_tc && !logits_full)
                m_err_timeout <= 1'b1;
            if (frame_full) begin
                timer     <= TMR_W'(TIMEOUT_CYCLES);
                logit_cnt <= '0;
            end else if (state == WAIT) begin
                timer <= timer - TMR_W'(1);
                if (logit_in_wait) logit_cnt <= logit_cnt + LCNT_W'(1);
            end
            if (core_result_valid && state != WAIT) stray_logit <= 1'b1;
            if (m_valid && m_ready) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    argmax_acc #(
        .LOGIT_W (LOGIT_W),
        .IDX_W   (CLS_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (frame_full),
        .valid      (logit_in_wait),
        .data       (core_result),
        .best_idx   (m_class),
        .best_score (m_score)
    );

endmodule

// File: tb/tb_mnist_frame_classifier.sv
// Directed bench for mnist_frame_classifier with a frame-level reference model
// and a per-cycle output compare process.
module tb_mnist_frame_classifier;

    localparam int TOTAL   = 784;
    localparam int NCLS    = 10;
    localparam int TIMEOUT = 100;

    logic        clk, rst_n;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_pixel;
    logic        core_valid_in;
    logic [7:0]  core_pixel;
    logic [31:0] core_result;
    logic        core_result_valid;
    logic        m_valid, m_ready;
    logic [3:0]  m_class;
    logic [31:0] m_score;
    logic        m_err_len, m_err_timeout, stray_logit;
    logic [15:0] frame_cnt;

    mnist_frame_classifier #(
        .PIX_W(8), .IMG_W(28), .IMG_H(28), .NUM_CLASSES(NCLS),
        .LOGIT_W(32), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_last(s_last),
        .core_valid_in(core_valid_in), .core_pixel(core_pixel),
        .core_result(core_result), .core_result_valid(core_result_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_score(m_score),
        .m_err_len(m_err_len), .m_err_timeout(m_err_timeout),
        .stray_logit(stray_logit), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wait_start = 0;

    // reference model state
    int lg [NCLS];
    int exp_class, exp_score, exp_frames;
    bit exp_len, exp_to, exp_stray;
    bit rec_acc;
    logic [7:0] rec_pix;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rec_acc <= s_valid & s_ready;
        rec_pix <= s_pixel;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench stopped");
    endtask

    // Expected result of a frame whose first n logits arrive in time.
    task automatic model(input int n);
        exp_class = 0;
        exp_score = 0;
        for (int k = 0; k < n; k++)
            if (k == 0 || lg[k] > exp_score) begin
                exp_score = lg[k];
                exp_class = k;
            end
        exp_to = (n < NCLS);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("core_valid_in", 32'(core_valid_in), 32'(rec_acc));
            if (rec_acc) chk("core_pixel", 32'(core_pixel), 32'(rec_pix));
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            chk("stray_logit", 32'(stray_logit), 32'(exp_stray));
            if (m_valid) begin
                chk("m_class", 32'(m_class), 32'(exp_class));
                chk("m_score", m_score, 32'(exp_score));
                chk("m_err_len", 32'(m_err_len), 32'(exp_len));
                chk("m_err_timeout", 32'(m_err_timeout), 32'(exp_to));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pixels(input int last_at, input int stop_at);
        int  budget;
        bit  lerr;
        lerr = 1'b0;
        for (int i = 1; i <= stop_at; i++) begin
            if (i % 97 == 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_pixel = 8'(i * 37 + 11);
            s_last  = (i == last_at);
            if (s_last != (i == TOTAL)) lerr = 1'b1;
            budget = 0;
            while (!s_ready && budget < 50) begin
                tick();
                budget++;
            end
            if (!s_ready) abort("s_ready_wait");
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_len = lerr;
    endtask

    task automatic send_logits(input int n);
        for (int k = 0; k < n; k++) begin
            if (k % 3 == 2) begin
                core_result_valid = 1'b0;
                tick();
            end
            core_result_valid = 1'b1;
            core_result       = lg[k];
            tick();
        end
        core_result_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!m_valid && budget < 400) begin
            tick();
            budget++;
        end
        if (!m_valid) abort("m_valid_wait");
    endtask

    task automatic handshake(input int hold);
        for (int h = 0; h < hold; h++) begin
            chk("hold_s_ready", 32'(s_ready), 0);
            chk("hold_m_valid", 32'(m_valid), 1);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        exp_frames++;
        chk("post_hs_m_valid", 32'(m_valid), 0);
        chk("post_hs_s_ready", 32'(s_ready), 1);
    endtask

    task automatic start_frame(input int last_at, input int n_model);
        model(n_model);
        send_pixels(last_at, TOTAL);
        wait_start = cyc;
        chk("wait_s_ready", 32'(s_ready), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        s_valid = 0; s_pixel = 0; s_last = 0;
        core_result = 0; core_result_valid = 0; m_ready = 0;
        exp_frames = 0; exp_stray = 0; exp_len = 0; exp_to = 0;
        exp_class = 0; exp_score = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_stray", 32'(stray_logit), 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // 1: basic frame, tie at 9 keeps index 2
        lg = '{-5, 3, 9, 9, 0, 1, 2, -7, 4, 8};
        start_frame(TOTAL, NCLS);
        send_logits(NCLS);
        wait_done();
        chk("t1_class", 32'(m_class), 2);
        chk("t1_score", m_score, 9);
        chk("t1_err_len", 32'(m_err_len), 0);
        chk("t1_err_to", 32'(m_err_timeout), 0);
        handshake(0);
        chk("t1_frame_cnt", 32'(frame_cnt), 1);

        // 2: extreme logits, result held 20 cycles under backpressure
        lg = '{32'sh8000_0000, 5, -9, 7, 7, 3, 32'sh7fff_ffff, 0, 1, 2};
        start_frame(TOTAL, NCLS);
        send_logits(NCLS);
        wait_done();
        chk("t2_class", 32'(m_class), 6);
        handshake(20);

        // 3: only 7 logits, timeout after exactly TIMEOUT wait cycles
        lg = '{-100, -20, -3, -50, -3, -80, -90, 0, 0, 0};
        start_frame(TOTAL, 7);
        send_logits(7);
        wait_done();
        chk("t3_latency", 32'(cyc - wait_start), 100);
        chk("t3_class", 32'(m_class), 2);
        chk("t3_score", m_score, 32'hffff_fffd);
        chk("t3_err_to", 32'(m_err_timeout), 1);
        handshake(1);

        // 4: early s_last, frame still closes on the count
        lg = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
        start_frame(500, NCLS);
        send_logits(NCLS);
        wait_done();
        chk("t4_err_len", 32'(m_err_len), 1);
        chk("t4_class", 32'(m_class), 9);
        handshake(0);

        // 5: stray logit in IDLE must not touch classification
        core_result_valid = 1'b1;
        core_result = 32'd1000;
        tick();
        core_result_valid = 1'b0;
        exp_stray = 1'b1;
        chk("t5_stray_set", 32'(stray_logit), 1);
        lg = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        start_frame(TOTAL, NCLS);
        send_logits(NCLS);
        wait_done();
        chk("t5_score", m_score, 32'hffff_ffff);
        handshake(0);
        chk("t5_stray_kept", 32'(stray_logit), 1);

        // 7: final logit on the expiry cycle completes the frame
        lg = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
        start_frame(TOTAL, NCLS);
        send_logits(9);
        while (cyc - wait_start < TIMEOUT - 1) tick();
        core_result_valid = 1'b1;
        core_result = lg[9];
        tick();
        core_result_valid = 1'b0;
        wait_done();
        chk("t7_latency", 32'(cyc - wait_start), 100);
        chk("t7_err_to", 32'(m_err_timeout), 0);
        chk("t7_class", 32'(m_class), 9);
        handshake(0);

        // 8: final logit one cycle late is a timeout and a stray
        start_frame(TOTAL, 9);
        send_logits(9);
        while (cyc - wait_start < TIMEOUT) tick();
        core_result_valid = 1'b1;
        core_result = lg[9];
        tick();
        core_result_valid = 1'b0;
        wait_done();
        chk("t8_err_to", 32'(m_err_timeout), 1);
        chk("t8_class", 32'(m_class), 0);
        chk("t8_score", m_score, 0);
        handshake(0);
        chk("t8_frame_cnt", 32'(frame_cnt), 7);

        // 6: reset mid-frame, then a clean frame
        send_pixels(TOTAL, 300);
        rst_n = 1'b0;
        #1;
        chk("t6_s_ready", 32'(s_ready), 0);
        chk("t6_core_valid", 32'(core_valid_in), 0);
        chk("t6_core_pixel", 32'(core_pixel), 0);
        chk("t6_m_valid", 32'(m_valid), 0);
        chk("t6_m_class", 32'(m_class), 0);
        chk("t6_m_score", m_score, 0);
        chk("t6_err_len", 32'(m_err_len), 0);
        chk("t6_err_to", 32'(m_err_timeout), 0);
        chk("t6_stray", 32'(stray_logit), 0);
        chk("t6_frame_cnt", 32'(frame_cnt), 0);
        exp_frames = 0;
        exp_stray  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        lg = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        start_frame(TOTAL, NCLS);
        send_logits(NCLS);
        wait_done();
        chk("t6_class", 32'(m_class), 5);
        chk("t6_score", m_score, 9);
        handshake(0);
        chk("t6_frames", 32'(frame_cnt), 1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
